// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Optional signed-overflow output is enabled by defining ALU_OVF_EN.
module alu_mdu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [4:0]       alu_op_i,
    input  logic [1:0]       mov_sel_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [WIDTH-1:0] data_in1_i,
    input  logic [WIDTH-1:0] data_in2_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             zero_o,
    output logic             sign_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
`ifdef ALU_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpSub  = 5'd1;
    localparam logic [4:0] OpSll  = 5'd2;
    localparam logic [4:0] OpSrl  = 5'd3;
    localparam logic [4:0] OpSra  = 5'd4;
    localparam logic [4:0] OpAnd  = 5'd5;
    localparam logic [4:0] OpOr   = 5'd6;
    localparam logic [4:0] OpXor  = 5'd7;
    localparam logic [4:0] OpNor  = 5'd8;
    localparam logic [4:0] OpSlt  = 5'd9;
    localparam logic [4:0] OpSltu = 5'd10;
    localparam logic [4:0] OpMult = 5'd11;
    localparam logic [4:0] OpDiv  = 5'd13;
    localparam logic [4:0] OpDivu = 5'd14;
    localparam logic [4:0] OpMfhi = 5'd15;
    localparam logic [4:0] OpMflo = 5'd16;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     magb_q, magb_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 zero_q, zero_d;
    logic                 sign_q, sign_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 mdu_op, signed_op, div_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [SHW-1:0]       sh_amt;
    logic [WIDTH-1:0]     sum, diff, alu_res;
    logic [WIDTH:0]       mul_acc, div_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem;

    assign mdu_op    = (alu_op_i >= OpMult) && (alu_op_i <= OpDivu);
    assign signed_op = (alu_op_i == OpMult) || (alu_op_i == OpDiv);
    assign div_op    = (alu_op_i == OpDiv) || (alu_op_i == OpDivu);
    assign a_neg     = signed_op & data_in1_i[WIDTH-1];
    assign b_neg     = signed_op & data_in2_i[WIDTH-1];
    assign a_mag     = a_neg ? -data_in1_i : data_in1_i;
    assign b_mag     = b_neg ? -data_in2_i : data_in2_i;
    assign sum       = data_in1_i + data_in2_i;
    assign diff      = data_in1_i - data_in2_i;

    // Selector 2 means "16" only for SLL; right shifts fall back to WIDTH-1.
    always_comb begin
        sh_amt = shamt_i;
        unique case (mov_sel_i)
            2'd0: sh_amt = shamt_i;
            2'd1: sh_amt = data_in1_i[SHW-1:0];
            2'd2: sh_amt = (alu_op_i == OpSll) ? SHW'(16) : SHW'(WIDTH - 1);
            2'd3: sh_amt = SHW'(WIDTH - 1);
            default: sh_amt = shamt_i;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            OpAdd:  alu_res = sum;
            OpSub:  alu_res = diff;
            OpSll:  alu_res = data_in2_i << sh_amt;
            OpSrl:  alu_res = data_in2_i >> sh_amt;
            OpSra:  alu_res = WIDTH'($signed(data_in2_i) >>> sh_amt);
            OpAnd:  alu_res = data_in1_i & data_in2_i;
            OpOr:   alu_res = data_in1_i | data_in2_i;
            OpXor:  alu_res = data_in1_i ^ data_in2_i;
            OpNor:  alu_res = ~(data_in1_i | data_in2_i);
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data_in1_i) < $signed(data_in2_i))};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (data_in1_i < data_in2_i)};
            OpMfhi: alu_res = hi_q;
            OpMflo: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // p_q holds {acc/remainder, multiplier/dividend}; both iterate one bit per cycle.
    assign mul_acc   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, magb_q} : '0);
    assign mul_next  = {mul_acc, p_q[WIDTH-1:1]};
    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, magb_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    assign prod = neg_q ? -p_q : p_q;
    assign quo  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        magb_d   = magb_q;
        opa_d    = opa_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        data_d   = data_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (mdu_op) begin
                        p_d      = {{WIDTH{1'b0}}, a_mag};
                        magb_d   = b_mag;
                        opa_d    = data_in1_i;
                        is_div_d = div_op;
                        neg_d    = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        div0_d   = div_op && (data_in2_i == '0);
                        cnt_d    = CW'(WIDTH);
                        state_d  = div_op ? StDiv : StMul;
                    end else begin
                        data_d = alu_res;
                        done_d = 1'b1;
                    end
                end
            end
            StMul: begin
                p_d   = mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = StFix;
            end
            StDiv: begin
                p_d   = div_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = StFix;
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                data_d  = lo_d;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        zero_d = (data_d == '0);
        sign_d = data_d[WIDTH-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p_q      <= '0;
            magb_q   <= '0;
            opa_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b1;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            magb_q   <= magb_d;
            opa_q    <= opa_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

`ifdef ALU_OVF_EN
    logic smul_q, smul_d;
    logic ovf_q, ovf_d;
    logic add_ovf, sub_ovf;

    assign add_ovf = (data_in1_i[WIDTH-1] == data_in2_i[WIDTH-1]) &&
                     (sum[WIDTH-1] != data_in1_i[WIDTH-1]);
    assign sub_ovf = (data_in1_i[WIDTH-1] != data_in2_i[WIDTH-1]) &&
                     (diff[WIDTH-1] != data_in1_i[WIDTH-1]);

    always_comb begin
        smul_d = smul_q;
        ovf_d  = ovf_q;
        if (state_q == StIdle && start_i) begin
            if (mdu_op) begin
                smul_d = (alu_op_i == OpMult);
            end else begin
                ovf_d = ((alu_op_i == OpAdd) && add_ovf) || ((alu_op_i == OpSub) && sub_ovf);
            end
        end else if (state_q == StFix) begin
            // Signed product fits only if the high half is the sign extension of the low half.
            ovf_d = smul_q && (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smul_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            smul_q <= smul_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign data_out_o = data_q;
    assign zero_o     = zero_q;
    assign sign_o     = sign_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: stimulus pushes expected results, a monitor pops on DONE.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = '0;
    logic [1:0]  mov = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [31:0] data_out, hi, lo;
    logic        zero, sign, busy, done;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    alu_mdu #(.WIDTH(32), .SHW(5)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .alu_op_i   (op),
        .mov_sel_i  (mov),
        .shamt_i    (shamt),
        .data_in1_i (in1),
        .data_in2_i (in2),
        .data_out_o (data_out),
        .zero_o     (zero),
        .sign_o     (sign),
        .busy_o     (busy),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo)
`ifdef ALU_OVF_EN
        ,
        .ovf_o      (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, ".data"}, data_out, e.data);
                check({n, ".zero"}, 32'(zero), 32'(e.data == 32'd0));
                check({n, ".sign"}, 32'(sign), 32'(e.data[31]));
                check({n, ".hi"}, hi, e.hi);
                check({n, ".lo"}, lo, e.lo);
`ifdef ALU_OVF_EN
                check({n, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic push(input string n, input logic [31:0] d, input logic [31:0] h,
                        input logic [31:0] l, input logic o);
        exp_t e;
        e.data = d;
        e.hi   = h;
        e.lo   = l;
        e.ovf  = o;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input logic [4:0] s);
        @(negedge clk);
        op = o; in1 = a; in2 = b; mov = m; shamt = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic single(input string n, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] m, input logic [4:0] s,
                          input logic [31:0] expv, input logic eovf);
        push(n, expv, hi_m, lo_m, eovf);
        issue(o, a, b, m, s);
    endtask

    // Multi-cycle op; optionally re-asserts START during BUSY for the first 'pokes' cycles.
    task automatic mdu(input string n, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic eovf, input int pokes);
        int busy_n = 0;
        int done_at = 0;
        push(n, el, eh, el, eovf);
        issue(o, a, b, 2'd0, 5'd0);
        hi_m = eh;
        lo_m = el;
        for (int i = 1; i <= 100 && done_at == 0; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) done_at = i;
            start = (i <= pokes);
            op    = 5'd0;
            in1   = 32'd1;
            in2   = 32'd1;
        end
        start = 1'b0;
        check({n, ".busy_cycles"}, busy_n, 32'd33);
        check({n, ".done_cycle"}, done_at, 32'd34);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst.data", data_out, 32'd0);
        check("rst.zero", 32'(zero), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        rst_n = 1'b1;

        single("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 2'd0, 5'd0, 32'h8000_0000, 1'b1);
        single("sub_zero", 5'd1, 32'd5, 32'd5, 2'd0, 5'd0, 32'd0, 1'b0);
        single("sra_in1", 5'd4, 32'h24, 32'h8000_0000, 2'd1, 5'd0, 32'hF800_0000, 1'b0);
        single("sll_16", 5'd2, 32'd0, 32'h1234, 2'd2, 5'd0, 32'h1234_0000, 1'b0);
        single("srl_c2", 5'd3, 32'd0, 32'h8000_0000, 2'd2, 5'd0, 32'd1, 1'b0);
        single("sll_shamt", 5'd2, 32'd0, 32'd1, 2'd0, 5'd3, 32'd8, 1'b0);
        single("and", 5'd5, 32'hF0F0, 32'hFF00, 2'd0, 5'd0, 32'hF000, 1'b0);
        single("or", 5'd6, 32'hF0F0, 32'hFF00, 2'd0, 5'd0, 32'hFFF0, 1'b0);
        single("xor", 5'd7, 32'hF0F0, 32'hFF00, 2'd0, 5'd0, 32'h0FF0, 1'b0);
        single("nor", 5'd8, 32'd0, 32'd0, 2'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        single("slt", 5'd9, 32'hFFFF_FFFF, 32'd1, 2'd0, 5'd0, 32'd1, 1'b0);
        single("sltu", 5'd10, 32'hFFFF_FFFF, 32'd1, 2'd0, 5'd0, 32'd0, 1'b0);
        single("undef_op", 5'd20, 32'd3, 32'd4, 2'd0, 5'd0, 32'd0, 1'b0);

        mdu("mult_neg", 5'd11, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 0);
        single("mfhi", 5'd15, 32'd0, 32'd0, 2'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        mdu("multu_max", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
        mdu("mult_ovf", 5'd11, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b1, 0);
        mdu("div_neg", 5'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        mdu("divu_zero", 5'd14, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0, 0);
        mdu("div_minneg", 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0);
        single("mflo", 5'd16, 32'd0, 32'd0, 2'd0, 5'd0, 32'h8000_0000, 1'b0);
        mdu("divu_rem", 5'd14, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
        mdu("multu_pokes", 5'd12, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 5);
        single("mfhi_after", 5'd15, 32'd0, 32'd0, 2'd0, 5'd0, 32'd0, 1'b0);

        issue(5'd13, 32'hFFFF_FFF9, 32'd2, 2'd0, 5'd0);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.data", data_out, 32'd0);
        check("midrst.zero", 32'(zero), 32'd1);
        check("midrst.sign", 32'(sign), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.hi", hi, 32'd0);
        check("midrst.lo", lo, 32'd0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        single("add_after_rst", 5'd0, 32'd2, 32'd3, 2'd0, 5'd0, 32'd5, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised, registered next-generation ALU for the CPU execute stage. It covers the full integer op set, WIDTH-generic with configurable shift source. It adds an iterative multiply/divide unit with HI/LO registers and a START/BUSY/DONE handshake. Single-cycle ops complete in one clock; MULT/DIV ops stall the pipeline via BUSY.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, at least 8.
SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
START  in  1  op request; sampled only when BUSY=0.
ALU_OP  in  5  op code: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 MFHI, 16 MFLO; 17-31 undefined.
MOV_SEL  in  2  shift source: 0 SHAMT, 1 DATA_IN1[SHW-1:0], 2 constant 16 (SLL only; SRL/SRA treat as 3), 3 constant WIDTH-1.
SHAMT  in  SHW  immediate shift amount.
DATA_IN1  in  WIDTH  operand A / rs.
DATA_IN2  in  WIDTH  operand B / rt; shifted operand.
DATA_OUT  out  WIDTH  registered result.
ZERO  out  1  registered; 1 when the registered DATA_OUT is 0.
SIGN  out  1  registered; DATA_OUT[WIDTH-1].
BUSY  out  1  multi-cycle op in progress.
DONE  out  1  one-cycle pulse: result valid.
HI  out  WIDTH  HI register (product high half / remainder).
LO  out  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (RST_N low, any time, including mid-operation): DATA_OUT=0, ZERO=1, SIGN=0, BUSY=0, DONE=0, HI=0, LO=0, FSM=IDLE, iteration counter=0. Any operation in progress is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, START=1, op 0-10 or 15-16:
  - DATA_OUT is registered at the same edge; DONE=1 for the following cycle; BUSY stays 0.
  - Latency is 1 cycle. Back-to-back STARTs yield one result per cycle.
- Single-cycle op results:
  - ADD/SUB: modulo 2^WIDTH.
  - SLL/SRL: logical shift. SRA: arithmetic shift.
  - Shift amount is selected by MOV_SEL and is always SHW bits wide (no over-shift).
  - SLT: signed compare. SLTU: unsigned compare. Both return 1 or 0.
  - MFHI/MFLO: DATA_OUT=HI or LO.
  - ALU_OP 17-31: DATA_OUT=0 with DONE pulsed.
- IDLE, START=1, op 11-14:
  - Operands are latched and the FSM enters MUL or DIV with BUSY=1.
  - The counter is loaded with WIDTH; there is one iteration per cycle.
- MUL: radix-2 shift-add on operand magnitudes over WIDTH cycles.
- DIV: restoring division on operand magnitudes over WIDTH cycles.
- FIX: one cycle that applies the signs and writes HI/LO.
  - DATA_OUT=LO value; DONE=1 in the next cycle; BUSY falls with DONE.
  - Total latency is START edge to DONE-high cycle = WIDTH+2 clocks. BUSY is high for WIDTH+1 cycles.
- Signed ops:
  - Product is negated when the operand signs differ.
  - Quotient sign = XOR of operand signs; remainder takes the dividend sign.
  - DIV of most-negative by -1: LO=most-negative, HI=0.
- Divide by zero (DIV/DIVU): LO=all ones, HI=dividend; same latency; no hang.
- START while BUSY=1 is ignored. No queueing; the master must hold the request until BUSY=0.
- HI/LO are updated only in FIX. DATA_OUT, ZERO and SIGN hold their values between ops.
- ZERO/SIGN are always consistent with DATA_OUT in the same cycle.

Optional Feature:
ALU_OVF_EN:
- Defined:
  - Adds output port OVF (1 bit, reset 0), registered with DATA_OUT.
  - OVF=1 on signed overflow of ADD/SUB, and on MULT when the 2*WIDTH product does not fit in WIDTH signed bits.
  - OVF=0 for all other ops.
- Undefined: OVF port and logic are absent; behaviour is otherwise identical.

Test Plan:
- ADD 0x7FFFFFFF+1, then SUB 5-5 back-to-back -> DATA_OUT=0x80000000, SIGN=1, DONE 1 cycle; next cycle DATA_OUT=0, ZERO=1 (OVF=1 then 0 if ALU_OVF_EN).
- SRA 0x80000000 with MOV_SEL=1, DATA_IN1=0x24 -> shift 4, DATA_OUT=0xF8000000; SLL 0x1234 with MOV_SEL=2 -> 0x12340000.
- MULT 0xFFFFFFFE * 3 -> BUSY 33 cycles, DONE at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFFA; then MFHI -> DATA_OUT=0xFFFFFFFF.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/0 -> LO=0xFFFFFFFF, HI=100, same latency.
- START pulses during BUSY -> ignored, single DONE, HI/LO match the first op only.
- RST_N low mid-DIV (cycle 10) -> all outputs at reset values immediately; a subsequent ADD 2+3 completes normally with DATA_OUT=5.
